// File: rtl/sub_sat_stage_pkg.sv
// Shared constants for the post-subtractor saturation stage: default widths,
// signed 16-bit clamp limits and the skid-FIFO occupancy encoding.
package sub_sat_stage_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/sub_sat_stage_sat_clamp.sv
// Combinational clamp of the subtractor difference to the signed limits
// according to its overflow flags.
module sat_clamp
  import sub_sat_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] diff_i,
  input  logic             op_i,
  input  logic             on_i,
  output logic [WIDTH-1:0] data_o,
  output logic             sat_o
);

  // Limits are derived from WIDTH so the block also works off the 16-bit default.
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    data_o = diff_i;
    if (op_i) begin
      data_o = MAX_V;
    end else if (on_i) begin
      data_o = MIN_V;
    end
  end

  assign sat_o = op_i | on_i;

endmodule

// File: rtl/sub_sat_stage.sv
// Saturation + 2-entry skid buffer behind the 16-bit subtractor, with a
// saturating count of clamped words accepted.
module sub_sat_stage
  import sub_sat_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_diff,
  input  logic             in_op,
  input  logic             in_on,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             head_sat_q, head_sat_d;
  logic [WIDTH-1:0] tail_data_q, tail_data_d;
  logic             tail_sat_q, tail_sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] clamp_data;
  logic             clamp_sat;
  logic             push, pop;

  sat_clamp #(.WIDTH(WIDTH)) u_sat_clamp (
    .diff_i (in_diff),
    .op_i   (in_op),
    .on_i   (in_on),
    .data_o (clamp_data),
    .sat_o  (clamp_sat)
  );

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = head_data_q;
  assign out_sat   = head_sat_q;
  assign sat_count = cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sat_d  = head_sat_q;
    tail_data_d = tail_data_q;
    tail_sat_d  = tail_sat_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_data_d = clamp_data;
          head_sat_d  = clamp_sat;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          tail_data_d = clamp_data;
          tail_sat_d  = clamp_sat;
          state_d     = ST_FULL;
        end else if (push && pop) begin
          head_data_d = clamp_data;
          head_sat_d  = clamp_sat;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Tail advances into head; no push can arrive while full.
        if (pop) begin
          head_data_d = tail_data_q;
          head_sat_d  = tail_sat_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = (push && clamp_sat) ? CNT_ONE : '0;
    end else if (push && clamp_sat && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_data_q <= '0;
      head_sat_q  <= 1'b0;
      tail_data_q <= '0;
      tail_sat_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sat_q  <= head_sat_d;
      tail_data_q <= tail_data_d;
      tail_sat_q  <= tail_sat_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/sub_sat_stage.md
# sub_sat_stage

Registered saturation and output-buffer stage directly downstream of the 16-bit signed subtractor in the multiplier datapath. Each cycle it accepts the subtractor difference and its positive/negative overflow flags, clamps overflowed results to the signed limits, and holds results in a 2-entry skid FIFO with a valid/ready handshake. A saturating event counter tracks how many clamped words have passed.

## Interface
- WIDTH, 16: data width of difference and output (signed two's complement).
- CNT_W, 8: width of saturation event counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  subtractor result valid.
- in_ready  out  1  stage can accept a word this cycle.
- in_diff  in  WIDTH  signed difference from subtractor.
- in_op  in  1  positive overflow flag from subtractor.
- in_on  in  1  negative overflow flag from subtractor.
- out_valid  out  1  out_data/out_sat valid.
- out_ready  in  1  consumer accepts head word.
- out_data  out  WIDTH  clamped result.
- out_sat  out  1  head word was clamped.
- sat_count  out  CNT_W  number of clamped words accepted, saturating.
- sat_clr  in  1  synchronous clear of sat_count.

## Operation
- Clamp (combinational on input): in_op=1 -> 0x7FFF (max positive for WIDTH); else in_on=1 -> 0x8000 (min negative); else in_diff. sat flag = in_op | in_on. in_op=in_on=1 is not producible by the subtractor; if seen, in_op wins.
- Push = in_valid & in_ready; pop = out_valid & out_ready. Clamped word + sat flag written to FIFO on push.
- FIFO states EMPTY(0), ONE(1), FULL(2):
  - EMPTY: push -> ONE.
  - ONE: push&!pop -> FULL; pop&!push -> EMPTY; push&pop -> ONE (head replaced by new word).
  - FULL: pop -> ONE; no push possible.
- in_ready = (state != FULL), derived from registered state only. out_valid = (state != EMPTY). out_data/out_sat driven from head register; outputs stable while out_valid & !out_ready.
- Order preserved; no word dropped or duplicated.
- sat_count: on push with sat flag, increments, saturates at 2^CNT_W-1 (no wrap). sat_clr has priority: sat_clr & counted push same cycle -> sat_count = 1; sat_clr alone -> 0.

## Timing
- Reset (rst=1 at edge): state EMPTY, out_valid=0, in_ready=1 after that edge, out_data=0, out_sat=0, sat_count=0. Reset mid-operation discards all buffered words immediately.
- Latency: word pushed at edge N visible on out_* after edge N (out_valid high in cycle N+1) when FIFO was EMPTY.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, accepts exactly 2 words, then in_ready=0 in the following cycle; in_ready returns high the cycle after the first pop.
- in_valid may be asserted regardless of in_ready; inputs ignored when in_ready=0.

## Structure
- Shared package: WIDTH default, SAT_MAX (0x7FFF) and SAT_MIN (0x8000) constants, FIFO state encoding (EMPTY/ONE/FULL, 2 bits).
- One sub-module: sat_clamp (combinational: in_diff, in_op, in_on -> clamped value, sat flag). FIFO, handshake and counter live in sub_sat_stage.

## Test plan
- Reset then push in_diff=0x1234, op=on=0, out_ready=1 -> next cycle out_data=0x1234, out_sat=0, sat_count=0.
- Push in_op=1 (diff=0x8001) then in_on=1 (diff=0x7FFF) -> out_data 0x7FFF then 0x8000, out_sat=1 both, sat_count=2.
- out_ready=0, push 3 consecutive words A,B,C -> only A,B accepted, in_ready=0 after second push; raise out_ready -> A,B emitted in order, then C accepted.
- Continuous push with out_ready=1 for 10 cycles -> 10 outputs back-to-back, in_ready never drops.
- CNT_W=8, push 260 saturating words -> sat_count stops at 255; sat_clr with a saturating push same cycle -> sat_count=1.
- FULL FIFO, assert rst for one cycle -> out_valid=0, in_ready=1, sat_count=0, no stale words emitted afterwards.
